// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin owner of the single RAM port shared by NUM_REQ masters
// (CPU on 0, DMA engines above). Registered one-hot grant, burst limit per tenure,
// one dead cycle on every ownership change, zero-latency mux of the owner's signals.
// Ports: clk, reset (async, active-high); req/req_addr/req_wr_en/req_wr_data in per master
// (flattened, slice i = master i); grant, owner_id, bus_busy; ram_addr/ram_wr_en/
// ram_wr_data/ram_en to the RAM.
// Optional: define ARB_PRIO0_EN to give requester 0 fixed top priority.
module mem_bus_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]        req_wr_en,
  input  logic [NUM_REQ*DATA_W-1:0] req_wr_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic [2:0]                owner_id,
  output logic                      bus_busy,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic                      ram_wr_en,
  output logic [DATA_W-1:0]         ram_wr_data,
  output logic                      ram_en
);

  localparam int TW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam logic [TW-1:0] LIM = TW'(MAX_BURST);
  localparam logic [2:0] LAST = 3'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);
`ifdef ARB_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    OWNED,
    GAP
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [NUM_REQ-1:0] grant_d;
  logic [2:0]         owner_d;
  logic [2:0]         rr_q;
  logic [2:0]         rr_d;
  logic [TW-1:0]      ten_q;
  logic [TW-1:0]      ten_d;
  logic [TW-1:0]      ten_inc;
  logic [2:0]         win_id;
  logic               found;
  logic               own_req;
  logic               others;
  logic               limit_hit;
  logic               preempt;
  logic               drop;

  // Round-robin scan starting at rr_q; one-hot masks avoid variable bit selects.
  always_comb begin
    int j;
    j      = 0;
    win_id = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && |(req & (ONE << j))) begin
        found  = 1'b1;
        win_id = 3'(j);
      end
    end
    if (PRIO0 && req[0]) win_id = '0;
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant;
    owner_d   = owner_id;
    rr_d      = rr_q;
    ten_d     = ten_q;
    own_req   = |(req & grant);
    others    = |(req & ~grant);
    ten_inc   = (ten_q == LIM) ? ten_q : ten_q + 1'b1;
    // ten_inc counts the current cycle, so the limit trips on the
    // MAX_BURST-th granted cycle.
    limit_hit = (MAX_BURST != 0) && (ten_inc == LIM);
    preempt   = PRIO0 && req[0] && !grant[0];
    drop      = !own_req || (limit_hit && others) || preempt;
    unique case (state_q)
      IDLE, GAP: begin
        if (|req) begin
          state_d = OWNED;
          grant_d = ONE << win_id;
          owner_d = win_id;
          ten_d   = '0;
        end else begin
          state_d = IDLE;
          grant_d = '0;
          owner_d = '0;
        end
      end
      OWNED: begin
        if (drop) begin
          state_d = GAP;
          grant_d = '0;
          owner_d = '0;
          ten_d   = '0;
          // CPU tenures under fixed priority leave the rotation alone.
          if (!(PRIO0 && grant[0]))
            rr_d = (owner_id == LAST) ? 3'd0 : owner_id + 3'd1;
        end else if (limit_hit) begin
          ten_d = '0;
        end else begin
          ten_d = ten_inc;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        owner_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      grant    <= '0;
      owner_id <= '0;
      rr_q     <= '0;
      ten_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant    <= grant_d;
      owner_id <= owner_d;
      rr_q     <= rr_d;
      ten_q    <= ten_d;
    end
  end

  assign bus_busy = |grant;

  // AND-OR mux on the one-hot grant: everything is zero while grant is zero.
  always_comb begin
    ram_addr    = '0;
    ram_wr_data = '0;
    ram_wr_en   = 1'b0;
    ram_en      = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        ram_addr    = ram_addr | req_addr[k*ADDR_W +: ADDR_W];
        ram_wr_data = ram_wr_data | req_wr_data[k*DATA_W +: DATA_W];
        ram_wr_en   = ram_wr_en | req_wr_en[k];
        ram_en      = ram_en | req[k];
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: scoreboard bench for mem_bus_arbiter (NUM_REQ=3, MAX_BURST=4).
// Honours ARB_PRIO0_EN when defined for the whole compile.
module tb_mem_bus_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 4;
`ifdef ARB_PRIO0_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]  req_wr_en;
  logic [N*DW-1:0] req_wr_data;
  logic [N-1:0]  grant;
  logic [2:0]    owner_id;
  logic          bus_busy;
  logic [AW-1:0] ram_addr;
  logic          ram_wr_en;
  logic [DW-1:0] ram_wr_data;
  logic          ram_en;

  mem_bus_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr),
    .req_wr_en(req_wr_en), .req_wr_data(req_wr_data),
    .grant(grant), .owner_id(owner_id), .bus_busy(bus_busy),
    .ram_addr(ram_addr), .ram_wr_en(ram_wr_en),
    .ram_wr_data(ram_wr_data), .ram_en(ram_en)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] g;
    logic [2:0] id;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   m_st, m_own, m_rr, m_cnt;
  logic [2:0] obs;
  logic       last_en;
  logic       last_we;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [2:0] r);
    int j;
    if (PRIO && r[0]) return 0;
    for (int k = 0; k < N; k++) begin
      j = (m_rr + k) % N;
      if (|(r & (3'b001 << j))) return j;
    end
    return -1;
  endfunction

  // Reference: m_cnt = granted cycles already completed in this tenure.
  task automatic model_step(input logic [2:0] r);
    int w;
    int c;
    logic [2:0] mine;
    if (m_st == 1) begin
      mine = 3'(1 << m_own);
      c = m_cnt + 1;
      if (!(|(r & mine)) || (PRIO && r[0] && m_own != 0) ||
          (c >= MB && |(r & ~mine))) begin
        if (!(PRIO && m_own == 0)) m_rr = (m_own + 1) % N;
        m_st  = 2;
        m_cnt = 0;
      end else begin
        m_cnt = (c >= MB) ? 0 : c;
      end
    end else begin
      w = pick(r);
      if (w >= 0) begin
        m_st  = 1;
        m_own = w;
        m_cnt = 0;
      end else begin
        m_st = 0;
      end
    end
    sb.push_back('{g: (m_st == 1) ? 3'(1 << m_own) : 3'b000,
                   id: (m_st == 1) ? 3'(m_own) : 3'd0});
  endtask

  task automatic model_reset();
    m_st = 0; m_own = 0; m_rr = 0; m_cnt = 0;
    sb.delete();
  endtask

  task automatic cycle(input logic [2:0] r, input logic [2:0] we);
    exp_t e;
    logic [2:0] mg;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    req = r;
    req_wr_en = we;
    #1;
    mg = (m_st == 1) ? 3'(1 << m_own) : 3'b000;
    ea = '0;
    ed = '0;
    if (|mg) begin
      ea = req_addr[m_own*AW +: AW];
      ed = req_wr_data[m_own*DW +: DW];
    end
    check("ram_en", 64'(ram_en), 64'(|(mg & r)));
    check("ram_wr_en", 64'(ram_wr_en), 64'(|(mg & we)));
    check("ram_addr", 64'(ram_addr), 64'(ea));
    check("ram_wr_data", 64'(ram_wr_data), 64'(ed));
    check("bus_busy", 64'(bus_busy), 64'(|mg));
    last_en = ram_en;
    last_we = ram_wr_en;
    model_step(r);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("grant", 64'(grant), 64'(e.g));
    check("owner_id", 64'(owner_id), 64'(e.id));
    obs = grant;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    req_wr_en = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_owner", 64'(owner_id), 64'd0);
    check("rst_busy", 64'(bus_busy), 64'd0);
    check("rst_ram_en", 64'(ram_en), 64'd0);
    reset = 1'b0;
    model_reset();
  endtask

  int cnt0, cnt1, cnt2, gaps, gcnt, wcnt;
  logic [2:0] t6_obs [4];
  logic [2:0] t6_exp [4];

  initial begin
    reset = 1'b1;
    req = '0;
    req_wr_en = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]    = 32'h80 << i;
      req_wr_data[i*DW +: DW] = 32'hD000_0000 | 32'(i);
    end
    model_reset();

    do_reset();
    cycle(3'b010, 3'b000);
    check("t1_grant", 64'(grant), 64'h2);
    check("t1_owner", 64'(owner_id), 64'h1);
    check("t1_addr", 64'(ram_addr), 64'h100);
    check("t1_busy", 64'(bus_busy), 64'h1);

    do_reset();
    cnt0 = 0; cnt1 = 0; cnt2 = 0; gaps = 0;
    for (int i = 0; i < 15; i++) begin
      cycle(3'b111, 3'b000);
      if (obs == 3'b001) cnt0++;
      if (obs == 3'b010) cnt1++;
      if (obs == 3'b100) cnt2++;
      if (obs == 3'b000) gaps++;
    end
    check("t2_m0_cycles", 64'(cnt0), PRIO ? 64'd12 : 64'd4);
    check("t2_m1_cycles", 64'(cnt1), PRIO ? 64'd0 : 64'd4);
    check("t2_m2_cycles", 64'(cnt2), PRIO ? 64'd0 : 64'd4);
    check("t2_gaps", 64'(gaps), 64'd3);

    do_reset();
    gcnt = 0; wcnt = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(3'b100, 3'b100);
      if (obs == 3'b100) gcnt++;
      if (last_we) wcnt++;
    end
    cycle(3'b000, 3'b100);
    if (last_we) wcnt++;
    check("t3_grant_cycles", 64'(gcnt), 64'd10);
    check("t3_wr_cycles", 64'(wcnt), 64'd10);
    check("t3_release", 64'(obs), 64'd0);

    do_reset();
    repeat (3) cycle(3'b110, 3'b000);
    cycle(3'b100, 3'b000);
    check("t4_en_drop", 64'(last_en), 64'd0);
    check("t4_gap", 64'(obs), 64'd0);
    cycle(3'b110, 3'b000);
    check("t4_rr_next", 64'(obs), 64'h4);
    cycle(3'b010, 3'b000);
    cycle(3'b000, 3'b000);

    do_reset();
    cycle(3'b010, 3'b000);
    cycle(3'b000, 3'b000);
    cycle(3'b010, 3'b000);
    cycle(3'b010, 3'b000);
    check("t5_owned", 64'(obs), 64'h2);
    #2;
    reset = 1'b1;
    #1;
    check("t5_async_grant", 64'(grant), 64'd0);
    check("t5_async_ram_en", 64'(ram_en), 64'd0);
    check("t5_async_busy", 64'(bus_busy), 64'd0);
    check("t5_async_owner", 64'(owner_id), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle(3'b110, 3'b000);
    check("t5_rr_reset", 64'(obs), 64'h2);

    do_reset();
    cycle(3'b100, 3'b000);
    cycle(3'b100, 3'b000);
    for (int i = 0; i < 4; i++) begin
      cycle(3'b101, 3'b000);
      t6_obs[i] = obs;
    end
    if (PRIO) begin
      t6_exp[0] = 3'b000; t6_exp[1] = 3'b001;
      t6_exp[2] = 3'b001; t6_exp[3] = 3'b001;
    end else begin
      t6_exp[0] = 3'b100; t6_exp[1] = 3'b100;
      t6_exp[2] = 3'b000; t6_exp[3] = 3'b001;
    end
    for (int i = 0; i < 4; i++)
      check($sformatf("t6_seq%0d", i), 64'(t6_obs[i]), 64'(t6_exp[i]));

    do_reset();
    for (int i = 0; i < 80; i++) begin
      req_addr    = {$urandom, $urandom, $urandom};
      req_wr_data = {$urandom, $urandom, $urandom};
      cycle(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single RAM port between NUM_REQ bus masters: CPU on requester 0, DMA read engine and DMA write engine on the others.
- Round-robin arbitration with a registered one-hot grant and a per-tenure burst limit.
- One dead cycle on every ownership change.
- Muxes the current owner's address, write enable and write data onto the RAM port.

Parameters:
- NUM_REQ, 3: number of requesters (2..8).
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- MAX_BURST, 8: maximum consecutive granted cycles per tenure; 0 = unlimited.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  bus request per master; held high for the whole transfer
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; slice i belongs to master i
- req_wr_en  in  NUM_REQ  write strobe per master
- req_wr_data  in  NUM_REQ*DATA_W  flattened write data
- grant  out  NUM_REQ  registered, one-hot or zero
- owner_id  out  3  index of current owner; 0 when no grant
- bus_busy  out  1  high when any grant is high
- ram_addr  out  ADDR_W  address muxed from owner
- ram_wr_en  out  1  req_wr_en[owner] AND grant active
- ram_wr_data  out  DATA_W  write data muxed from owner
- ram_en  out  1  high when a grant is active and req[owner] is high

Behaviour:
- Reset (asynchronous, immediate, also mid-transfer):
  - grant=0, owner_id=0, state=IDLE, rr_ptr=0, tenure=0.
  - All ram_* outputs and bus_busy are 0. These are combinational from grant, so they are zero whenever grant=0.
- States: IDLE, OWNED, GAP.
- Arbitration (combinational): winner = first i with req[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
- IDLE:
  - If req is nonzero, grant[winner] is set at the next edge and the state goes to OWNED. Latency: req high in cycle n gives grant high in cycle n+1.
  - Otherwise stay in IDLE.
- OWNED:
  - tenure increments on each granted cycle. Width is clog2(MAX_BURST+1), saturating at MAX_BURST.
  - Release when req[owner]=0, or when tenure reaches MAX_BURST while some other req[j] is high.
  - On release: grant=0 at the next edge, rr_ptr=(owner+1) mod NUM_REQ, tenure=0, state goes to GAP.
  - Limit reached with no other requester: the owner keeps the grant, tenure resets to 0, and there is no gap.
- GAP:
  - Exactly one cycle with grant=0.
  - If req is nonzero, grant[winner] is set at the next edge and the state goes to OWNED; otherwise go to IDLE.
  - A master dropping and re-raising req in GAP is treated like any other requester.
- Requests that fall while not granted have no effect and are not latched.
- Simultaneous requests in the same cycle are resolved purely by rr_ptr order.
- The owner's outputs are passed through the mux with zero added latency. Non-owner inputs are ignored.
- A master that lowers req releases the bus; its ram_en is already 0 in that cycle.
- A master receiving grant=0 while still requesting (burst-limit preemption) must hold its transfer until it is granted again. The DMA engines already wait in their data state for this.

Optional Feature:
- Macro: ARB_PRIO0_EN
- Defined: requester 0 (CPU) has fixed top priority.
  - Arbitration picks master 0 whenever req[0]=1, ignoring rr_ptr.
  - If another master owns the bus and req[0] rises, the owner is released at the next edge (one-cycle GAP), regardless of tenure, and master 0 is granted after the GAP.
  - rr_ptr is not updated by master 0's tenures.
- Undefined: pure round-robin; master 0 is treated like any other requester.

Test Plan (NUM_REQ=3, MAX_BURST=4):
- Reset release, req=3'b010 in cycle 0 -> grant=3'b010 in cycle 1, owner_id=1, ram_addr equals slice 1 of req_addr (0x100), bus_busy=1.
- req=3'b111 simultaneously from IDLE after reset -> grant order 001, GAP, 010, GAP, 100, with 4 granted cycles each and exactly one grant=0 cycle between tenures.
- Master 2 alone requests for 10 cycles with req_wr_en=1 -> grant held for 10 cycles with no gap, ram_wr_en=1 for 10 cycles.
- Master 1 owns the bus and drops req after 2 cycles while master 2 is requesting -> grant=0 for 1 cycle, then grant=3'b100, and rr_ptr then points to requester 2.
- Reset asserted mid-tenure with master 1 granted -> grant=0 and ram_en=0 in the same cycle, without waiting for the next clock edge. After release with req=3'b110, master 1 wins because rr_ptr=0.
- ARB_PRIO0_EN defined, master 2 owning the bus at tenure 1, req[0] rises -> grant=0 at the next edge, grant=3'b001 one cycle later. Without the macro, master 2 finishes 4 cycles before master 0 is granted.
